// File: rtl/rr_x_in_arb_if.sv
// Handshake bundle between requesters and the round-robin arbiter.
// Suffixes are from the arbiter's point of view.
interface rr_x_in_arb_if #(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
);
    logic [IO_SIZE-1:0] req_i;
    logic               release_i;
    logic [IO_SIZE-1:0] grant_o;
    logic               grant_vld_o;
    logic [IO_w-1:0]    grant_id_o;
    logic [IO_w-1:0]    ptr_o;

    // Requester side: drives requests and release, observes the grant.
    modport master (
        output req_i,
        output release_i,
        input  grant_o,
        input  grant_vld_o,
        input  grant_id_o,
        input  ptr_o
    );

    // Arbiter side.
    modport slave (
        input  req_i,
        input  release_i,
        output grant_o,
        output grant_vld_o,
        output grant_id_o,
        output ptr_o
    );
endinterface

// File: rtl/rr_x_in_arb.sv
// Round-robin arbiter: one registered one-hot grant held until released.
// Priority starts at ptr and wraps; ptr moves past the owner on release.
module rr_x_in_arb #(
    parameter int IO_SIZE = 5,
    parameter int IO_w    = 3
) (
    input  logic        clk,
    input  logic        rst,
    rr_x_in_arb_if.slave arb
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [IO_w:0] SZ = (IO_w+1)'(IO_SIZE);

    state_t             state_q, state_d;
    logic [IO_w-1:0]    ptr_q, ptr_d;
    logic [IO_SIZE-1:0] grant_q, grant_d;
    logic [IO_w-1:0]    id_q, id_d;
    logic               vld_q, vld_d;

    logic [2*IO_SIZE-1:0] dbl;
    logic [IO_SIZE-1:0]   rot;
    logic [IO_w:0]        k;
    logic [IO_w:0]        sum;
    logic [IO_w:0]        nxt;
    logic [IO_w-1:0]      winner;
    logic                 owner_req;

    // Rotate req so bit ptr sits at bit 0, then pick the lowest set bit.
    always_comb begin
        dbl = {arb.req_i, arb.req_i} >> ptr_q;
        rot = dbl[IO_SIZE-1:0];
        k   = '0;
        for (int j = IO_SIZE - 1; j >= 0; j--) begin
            if (rot[j]) k = (IO_w+1)'(j);
        end
        sum = {1'b0, ptr_q} + k;
        if (sum >= SZ) sum = sum - SZ;
        winner = sum[IO_w-1:0];
        nxt = {1'b0, id_q} + 1'b1;
        if (nxt >= SZ) nxt = '0;
        owner_req = |(arb.req_i & grant_q);
    end

    // Next-state logic: grant in IDLE, hold in BUSY until a release event.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (|arb.req_i) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    id_d            = winner;
                    vld_d           = 1'b1;
                    state_d         = BUSY;
                end
            end
            BUSY: begin
                if (arb.release_i || !owner_req) begin
                    grant_d = '0;
                    id_d    = '0;
                    vld_d   = 1'b0;
                    ptr_d   = nxt[IO_w-1:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset overrides everything, including mid-grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            vld_q   <= vld_d;
        end
    end

    assign arb.grant_o     = grant_q;
    assign arb.grant_vld_o = vld_q;
    assign arb.grant_id_o  = id_q;
    assign arb.ptr_o       = ptr_q;
endmodule
